axi_trace_record_packer: RTL and testbench

//  Consumes the five packed AXI trace streams (AW, W, B, AR, R) produced by the AXI trace monitor.

---
 rtl/axi_trace_pkg.sv | 33 +++
 rtl/axi_trace_chan_fifo.sv | 52 +++++
 rtl/axi_trace_record_packer.sv | 141 ++++++++++++++
 tb/tb_axi_trace_record_packer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_trace_pkg.sv
// Shared channel tags and width helpers for the AXI trace record packer.
// The payload field is sized to fit the widest of the five channel trace streams.
package axi_trace_pkg;

  typedef enum logic [2:0] {
    CH_AW = 3'd0,
    CH_W  = 3'd1,
    CH_B  = 3'd2,
    CH_AR = 3'd3,
    CH_R  = 3'd4
  } chan_tag_e;

  localparam logic [2:0] TAG_AW = CH_AW;
  localparam logic [2:0] TAG_W  = CH_W;
  localparam logic [2:0] TAG_B  = CH_B;
  localparam logic [2:0] TAG_AR = CH_AR;
  localparam logic [2:0] TAG_R  = CH_R;
  localparam int NUM_CH = 5;

  function automatic int payw(int addrw, int dataw, int lengthw, int sizew, int idw);
    int a, w, r, m;
    a = addrw + lengthw + sizew + idw + 2;
    w = dataw + dataw / 8 + idw + 1;
    r = dataw + idw + 3;
    m = (a > w) ? a : w;
    return (m > r) ? m : r;
  endfunction

  function automatic int recw(int tsw, int payw_v);
    return 3 + tsw + payw_v;
  endfunction

endpackage

// File: rtl/axi_trace_chan_fifo.sv
// Synchronous per-channel capture FIFO with count-based full/empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module axi_trace_chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_trace_record_packer.sv
// Captures AXI trace handshakes on five channels, timestamps and tags them, and
// serialises them round-robin into a single record stream with drop accounting.
module axi_trace_record_packer
  import axi_trace_pkg::*;
#(
  parameter int ADDRW    = 32,
  parameter int DATAW    = 32,
  parameter int LENGTHW  = 4,
  parameter int SIZEW    = 3,
  parameter int IDW      = 1,
  parameter int TSW      = 32,
  parameter int CH_DEPTH = 4,
  localparam int AWW     = ADDRW + LENGTHW + SIZEW + IDW + 2,
  localparam int WW      = DATAW + DATAW / 8 + IDW + 1,
  localparam int BW      = 2 + IDW,
  localparam int RW      = DATAW + IDW + 3,
  localparam int PAYW    = payw(ADDRW, DATAW, LENGTHW, SIZEW, IDW),
  localparam int RECW    = recw(TSW, PAYW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trace_en,
  input  logic            aw_valid,
  input  logic            aw_ready,
  input  logic [AWW-1:0]  aw_data,
  input  logic            w_valid,
  input  logic            w_ready,
  input  logic [WW-1:0]   w_data,
  input  logic            b_valid,
  input  logic            b_ready,
  input  logic [BW-1:0]   b_data,
  input  logic            ar_valid,
  input  logic            ar_ready,
  input  logic [AWW-1:0]  ar_data,
  input  logic            r_valid,
  input  logic            r_ready,
  input  logic [RW-1:0]   r_data,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [RECW-1:0] rec_data,
  output logic [31:0]     drop_cnt,
  output logic            overflow
);

  logic [TSW-1:0]    ts;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] drop;
  logic [RECW-1:0]   fifo_in  [NUM_CH];
  logic [RECW-1:0]   fifo_out [NUM_CH];
  logic [2:0]        rr_ptr;
  logic [2:0]        grant_idx;
  logic              grant_valid;
  logic [3:0]        cand_sum;
  logic [2:0]        cand;
  logic              load;
  logic [2:0]        drop_sum;
  logic [32:0]       drop_next;

  assign fire = {NUM_CH{trace_en}} & {r_valid && r_ready, ar_valid && ar_ready,
                                      b_valid && b_ready, w_valid && w_ready,
                                      aw_valid && aw_ready};

  assign fifo_in[0] = {TAG_AW, ts, PAYW'(aw_data)};
  assign fifo_in[1] = {TAG_W,  ts, PAYW'(w_data)};
  assign fifo_in[2] = {TAG_B,  ts, PAYW'(b_data)};
  assign fifo_in[3] = {TAG_AR, ts, PAYW'(ar_data)};
  assign fifo_in[4] = {TAG_R,  ts, PAYW'(r_data)};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    axi_trace_chan_fifo #(
      .WIDTH (RECW),
      .DEPTH (CH_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fire[i]),
      .pop   (pop[i]),
      .din   (fifo_in[i]),
      .dout  (fifo_out[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign load = !rec_valid || rec_ready;

  // Scan from the farthest offset down so the nearest non-empty channel after rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand_sum    = '0;
    cand        = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + 4'(k);
      cand     = (cand_sum >= 4'd5) ? 3'(cand_sum - 4'd5) : cand_sum[2:0];
      if (!empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_valid) pop[grant_idx] = 1'b1;
  end

  assign drop = fire & full & ~pop;

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + 3'(drop[i]);
    drop_next = {1'b0, drop_cnt} + 33'(drop_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= '0;
      rr_ptr    <= TAG_AW;
      rec_valid <= 1'b0;
      rec_data  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      ts <= ts + TSW'(1);
      if (load) begin
        rec_valid <= grant_valid;
        if (grant_valid) begin
          rec_data <= fifo_out[grant_idx];
          rr_ptr   <= (grant_idx == TAG_R) ? TAG_AW : grant_idx + 3'd1;
        end
      end
      drop_cnt <= drop_next[32] ? 32'hFFFF_FFFF : drop_next[31:0];
      if (drop != '0) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_trace_record_packer.sv
// Self-checking bench: directed scenarios plus a randomized phase, all compared
// against a queue-based behavioural model of the record packer.
module tb_axi_trace_record_packer;
  import axi_trace_pkg::*;

  localparam int ADDRW = 32, DATAW = 32, LENGTHW = 4, SIZEW = 3, IDW = 1, TSW = 32;
  localparam int DEPTH = 4;
  localparam int AWW  = ADDRW + LENGTHW + SIZEW + IDW + 2;
  localparam int WW   = DATAW + DATAW / 8 + IDW + 1;
  localparam int BW   = 2 + IDW;
  localparam int RW   = DATAW + IDW + 3;
  localparam int PAYW = payw(ADDRW, DATAW, LENGTHW, SIZEW, IDW);
  localparam int RECW = recw(TSW, PAYW);

  typedef logic [RECW-1:0] rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trace_en = 1'b1;
  logic aw_valid = 0, aw_ready = 0, w_valid = 0, w_ready = 0, b_valid = 0, b_ready = 0;
  logic ar_valid = 0, ar_ready = 0, r_valid = 0, r_ready = 0;
  logic [AWW-1:0] aw_data = '0, ar_data = '0;
  logic [WW-1:0]  w_data = '0;
  logic [BW-1:0]  b_data = '0;
  logic [RW-1:0]  r_data = '0;
  logic           rec_valid;
  logic           rec_ready = 1'b1;
  logic [RECW-1:0] rec_data;
  logic [31:0]    drop_cnt;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  rec_t        mq [NUM_CH][$];
  logic        m_valid;
  rec_t        m_data;
  longint      m_drop;
  logic        m_ovf;
  logic [31:0] m_ts;
  int          m_rr;

  axi_trace_record_packer dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_data(aw_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_data(ar_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic chan_fire(int ch);
    case (ch)
      0: return trace_en && aw_valid && aw_ready;
      1: return trace_en && w_valid && w_ready;
      2: return trace_en && b_valid && b_ready;
      3: return trace_en && ar_valid && ar_ready;
      default: return trace_en && r_valid && r_ready;
    endcase
  endfunction

  function automatic logic [PAYW-1:0] chan_pay(int ch);
    case (ch)
      0: return PAYW'(aw_data);
      1: return PAYW'(w_data);
      2: return PAYW'(b_data);
      3: return PAYW'(ar_data);
      default: return PAYW'(r_data);
    endcase
  endfunction

  // Reference model: one call per rising edge, using the inputs held across that edge.
  task automatic modelTick();
    int g;
    int n;
    int c;
    rec_t pdata;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_valid = 1'b0; m_data = '0; m_drop = 0; m_ovf = 1'b0; m_ts = '0; m_rr = 0;
      return;
    end
    g = -1;
    n = 0;
    pdata = '0;
    if (!m_valid || rec_ready) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (mq[c].size() > 0) begin
          g = c;
          break;
        end
      end
    end
    if (g >= 0) pdata = mq[g].pop_front();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (chan_fire(ch)) begin
        if (mq[ch].size() < DEPTH) mq[ch].push_back({3'(ch), m_ts, chan_pay(ch)});
        else n++;
      end
    end
    if (n > 0) m_ovf = 1'b1;
    m_drop = m_drop + n;
    if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
    if (!m_valid || rec_ready) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = pdata;
        m_rr = (g + 1) % NUM_CH;
      end
    end
    m_ts = m_ts + 32'd1;
  endtask

  task automatic checkVal(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (rec_valid === m_valid) else begin
      errors++;
      $error("[TB] FAIL %s rec_valid: observed %b expected %b", tag, rec_valid, m_valid);
    end
    checks++;
    assert (rec_data === m_data) else begin
      errors++;
      $error("[TB] FAIL %s rec_data: observed 0x%0h expected 0x%0h", tag, rec_data, m_data);
    end
    checks++;
    assert (drop_cnt === m_drop[31:0]) else begin
      errors++;
      $error("[TB] FAIL %s drop_cnt: observed %0d expected %0d", tag, drop_cnt, m_drop);
    end
    checks++;
    assert (overflow === m_ovf) else begin
      errors++;
      $error("[TB] FAIL %s overflow: observed %b expected %b", tag, overflow, m_ovf);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelTick();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic [4:0] fires);
    aw_valid = fires[0]; aw_ready = fires[0]; aw_data = AWW'({$urandom(), $urandom()});
    w_valid  = fires[1]; w_ready  = fires[1]; w_data  = WW'({$urandom(), $urandom()});
    b_valid  = fires[2]; b_ready  = fires[2]; b_data  = BW'($urandom());
    ar_valid = fires[3]; ar_ready = fires[3]; ar_data = AWW'({$urandom(), $urandom()});
    r_valid  = fires[4]; r_ready  = fires[4]; r_data  = RW'({$urandom(), $urandom()});
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(5'b0);
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [AWW-1:0] aw_t1;
    logic [RECW-1:0] held;
    longint last_ts;
    logic pv, pr;
    logic [RECW-1:0] pd;

    // Test 1: single AW fire at ts=10, record appears two cycles later.
    resetDut();
    checkVal("reset_valid", 128'(rec_valid), 128'(0));
    checkVal("reset_data", 128'(rec_data), 128'(0));
    repeat (10) step("t1_idle");
    aw_t1 = {1'b0, 3'd2, 4'd3, 2'b01, 32'h0000_1000};
    applyStimulus(5'b00001);
    aw_data = aw_t1;
    step("t1_fire");
    applyStimulus(5'b0);
    step("t1_out");
    checkVal("t1_valid", 128'(rec_valid), 128'(1));
    checkVal("t1_tag", 128'(rec_data[RECW-1 -: 3]), 128'(0));
    checkVal("t1_ts", 128'(rec_data[PAYW +: TSW]), 128'(10));
    checkVal("t1_payload", 128'(rec_data[PAYW-1:0]), 128'(aw_t1));

    // Test 2: all channels fire at ts=20, emitted in tag order on consecutive cycles.
    resetDut();
    repeat (20) step("t2_idle");
    applyStimulus(5'b11111);
    step("t2_fire");
    applyStimulus(5'b0);
    step("t2_gap");
    for (int i = 0; i < NUM_CH; i++) begin
      checkVal("t2_valid", 128'(rec_valid), 128'(1));
      checkVal("t2_tag", 128'(rec_data[RECW-1 -: 3]), 128'(i));
      checkVal("t2_ts", 128'(rec_data[PAYW +: TSW]), 128'(20));
      step("t2_drain");
    end
    checkVal("t2_idle_after", 128'(rec_valid), 128'(0));

    // Test 3: stalled sink, six W fires overflow a depth-4 FIFO by one.
    resetDut();
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(5'b00010);
      step("t3_fill");
    end
    applyStimulus(5'b0);
    step("t3_hold");
    checkVal("t3_drop_cnt", 128'(drop_cnt), 128'(1));
    checkVal("t3_overflow", 128'(overflow), 128'(1));
    held = rec_data;
    step("t3_stall");
    checkVal("t3_stable", 128'(rec_data), 128'(held));

    // Test 4: push into a full FIFO in the same cycle as its pop is accepted.
    rec_ready = 1'b1;
    applyStimulus(5'b00010);
    step("t4_push_pop");
    applyStimulus(5'b0);
    checkVal("t4_drop_cnt", 128'(drop_cnt), 128'(1));
    last_ts = -1;
    for (int i = 0; i < 7; i++) begin
      if (rec_valid) begin
        checkVal("t3_ts_order", 128'(longint'(rec_data[PAYW +: TSW]) > last_ts), 128'(1));
        last_ts = longint'(rec_data[PAYW +: TSW]);
      end
      step("t3_drain");
    end
    checkVal("t4_drained", 128'(rec_valid), 128'(0));

    // Test 5: disabled capture ignores handshakes without counting drops.
    resetDut();
    trace_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'b10000);
      step("t5_disabled");
    end
    applyStimulus(5'b0);
    step("t5_gap");
    step("t5_gap");
    checkVal("t5_no_rec", 128'(rec_valid), 128'(0));
    checkVal("t5_no_drop", 128'(drop_cnt), 128'(0));
    trace_en = 1'b1;
    applyStimulus(5'b10000);
    step("t5_fire");
    applyStimulus(5'b0);
    step("t5_out");
    checkVal("t5_valid", 128'(rec_valid), 128'(1));
    checkVal("t5_tag", 128'(rec_data[RECW-1 -: 3]), 128'(4));
    step("t5_after");
    checkVal("t5_single", 128'(rec_valid), 128'(0));

    // Test 6: reset while records are pending and the output is stalled.
    resetDut();
    rec_ready = 1'b0;
    applyStimulus(5'b00111);
    step("t6_fire");
    applyStimulus(5'b0);
    step("t6_gap");
    step("t6_pending");
    checkVal("t6_pending_valid", 128'(rec_valid), 128'(1));
    rst = 1'b1;
    step("t6_rst");
    rst = 1'b0;
    checkVal("t6_rst_valid", 128'(rec_valid), 128'(0));
    checkVal("t6_rst_drop", 128'(drop_cnt), 128'(0));
    checkVal("t6_rst_ovf", 128'(overflow), 128'(0));
    rec_ready = 1'b1;
    applyStimulus(5'b00001);
    step("t6_fire2");
    applyStimulus(5'b0);
    step("t6_out");
    checkVal("t6_ts_zero", 128'(rec_data[PAYW +: TSW]), 128'(0));
    step("t6_after");
    checkVal("t6_flushed", 128'(rec_valid), 128'(0));

    // Randomized traffic with backpressure against the model.
    resetDut();
    for (int i = 0; i < 600; i++) begin
      aw_valid = ($urandom_range(1) == 1); aw_ready = ($urandom_range(3) != 0);
      w_valid  = ($urandom_range(1) == 1); w_ready  = ($urandom_range(3) != 0);
      b_valid  = ($urandom_range(1) == 1); b_ready  = ($urandom_range(3) != 0);
      ar_valid = ($urandom_range(1) == 1); ar_ready = ($urandom_range(3) != 0);
      r_valid  = ($urandom_range(1) == 1); r_ready  = ($urandom_range(3) != 0);
      aw_data = AWW'({$urandom(), $urandom()});
      w_data  = WW'({$urandom(), $urandom()});
      b_data  = BW'($urandom());
      ar_data = AWW'({$urandom(), $urandom()});
      r_data  = RW'({$urandom(), $urandom()});
      trace_en  = ($urandom_range(7) != 0);
      rec_ready = (i % 100 < 20) ? 1'b0 : ($urandom_range(1) == 1);
      pv = rec_valid; pr = rec_ready; pd = rec_data;
      step("rand");
      if (pv && !pr) begin
        checkVal("rand_stall_valid", 128'(rec_valid), 128'(1));
        checkVal("rand_stall_data", 128'(rec_data), 128'(pd));
      end
    end
    applyStimulus(5'b0);
    trace_en = 1'b1;
    rec_ready = 1'b1;
    repeat (30) step("rand_drain");
    checkVal("rand_empty", 128'(rec_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
